microcode_sequencer: RTL and testbench

Sequences the 256-word × 64-bit microcode EPROM: it generates the ROM address, drives its active-low chip-select/output-enable for a configurable access time, latches the returned microword into a pipeline register, and computes the next address from sequencing fields carried in the microword itself. It sits between the microcode EPROM and the CPU control decode. It supports increment, jump, conditional branch, call/return via a 4-deep return stack, opcode dispatch, wait-on-condition and halt.

---
 rtl/microcode_sequencer_if.sv | 13 +
 rtl/microcode_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_microcode_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/microcode_sequencer_if.sv
// EPROM-side bus of the microcode sequencer: address, active-low selects, returned data.
interface microcode_sequencer_if;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 64;

  logic [AW-1:0] rom_addr;
  logic          _rom_cs;
  logic          _rom_oe;
  logic [DW-1:0] rom_data;

  modport master (output rom_addr, output _rom_cs, output _rom_oe, input rom_data);
  modport slave  (input rom_addr, input _rom_cs, input _rom_oe, output rom_data);
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches 64-bit microwords from EPROM with a programmable
// access time, holds them for execution and computes the next microaddress
// from the sequencing fields of the current word (4-deep return stack).
module microcode_sequencer #(
  parameter int unsigned ROM_WAIT     = 2,
  parameter logic [7:0]  RESET_VECTOR = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   opcode,
  input  logic [7:0]                   cond,
  input  logic                         stall,
  microcode_sequencer_if.master        rom,
  output logic [63:0]                  uword,
  output logic                         uword_valid,
  output logic                         busy,
  output logic                         fault
);

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SPW   = 3;
  localparam int unsigned WCW   = 3;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;
  typedef enum logic [2:0] {
    OP_NEXT, OP_JUMP, OP_JCOND, OP_CALL, OP_RET, OP_DISPATCH, OP_HALT, OP_WAIT
  } seq_op_t;

  state_t                    r_state, w_state;
  logic [AW-1:0]             r_addr, w_addr;
  logic                      r_cs_n, w_cs_n;
  logic [DW-1:0]             r_uword, w_uword;
  logic                      r_valid, w_valid;
  logic                      r_busy, w_busy;
  logic                      r_fault, w_fault;
  logic [SPW-1:0]            r_sp, w_sp;
  logic [DEPTH-1:0][AW-1:0]  r_stack, w_stack;
  logic [WCW-1:0]            r_wcnt, w_wcnt;

  seq_op_t                   w_seq_op;
  logic [2:0]                w_cond_sel;
  logic [AW-1:0]             w_target;
  logic [AW-1:0]             w_addr_inc;
  logic [SPW-1:0]            w_sp_dec;
  logic                      w_cond_hit;
  logic [AW-1:0]             w_next_addr;
  logic                      w_stop;
  logic                      w_err;
  logic                      w_hold;

  // Sequencing fields decoded from the latched microword
  assign w_seq_op   = seq_op_t'(r_uword[63:61]);
  assign w_cond_sel = r_uword[60:58];
  assign w_target   = r_uword[57:50];
  assign w_addr_inc = r_addr + AW'(1);
  assign w_sp_dec   = r_sp - SPW'(1);
  assign w_cond_hit = cond[w_cond_sel];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cs_n  <= 1'b1;
      r_uword <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
      r_sp    <= '0;
      r_stack <= '0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_cs_n  <= w_cs_n;
      r_uword <= w_uword;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_fault <= w_fault;
      r_sp    <= w_sp;
      r_stack <= w_stack;
      r_wcnt  <= w_wcnt;
    end
  end

  // Next-state, next-address and register-update logic
  always_comb begin
    w_state     = r_state;
    w_addr      = r_addr;
    w_cs_n      = r_cs_n;
    w_uword     = r_uword;
    w_valid     = r_valid;
    w_busy      = r_busy;
    w_fault     = r_fault;
    w_sp        = r_sp;
    w_stack     = r_stack;
    w_wcnt      = r_wcnt;
    w_next_addr = w_addr_inc;
    w_stop      = 1'b0;
    w_err       = 1'b0;
    w_hold      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_FETCH;
          w_addr  = RESET_VECTOR;
          w_cs_n  = 1'b0;
          w_busy  = 1'b1;
          w_sp    = '0;
          w_wcnt  = '0;
        end
      end

      S_FETCH: begin
        if (r_wcnt == WCW'(ROM_WAIT)) begin
          w_uword = rom.rom_data;
          w_state = S_EXEC;
          w_valid = 1'b1;
          w_cs_n  = 1'b1;
        end else begin
          w_wcnt = r_wcnt + WCW'(1);
        end
      end

      S_EXEC: begin
        // A stalled microword is frozen regardless of its seq_op
        if (!stall) begin
          case (w_seq_op)
            OP_NEXT:     w_next_addr = w_addr_inc;
            OP_JUMP:     w_next_addr = w_target;
            OP_JCOND:    w_next_addr = w_cond_hit ? w_target : w_addr_inc;
            OP_CALL: begin
              if (r_sp == SPW'(DEPTH)) begin
                w_err = 1'b1;
              end else begin
                w_stack[r_sp[1:0]] = w_addr_inc;
                w_sp               = r_sp + SPW'(1);
                w_next_addr        = w_target;
              end
            end
            OP_RET: begin
              if (r_sp == '0) begin
                w_err = 1'b1;
              end else begin
                w_sp        = w_sp_dec;
                w_next_addr = r_stack[w_sp_dec[1:0]];
              end
            end
            OP_DISPATCH: w_next_addr = opcode;
            OP_HALT:     w_stop      = 1'b1;
            OP_WAIT:     w_hold      = !w_cond_hit;
            default:     w_next_addr = w_addr_inc;
          endcase

          if (w_stop || w_err) begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
            w_valid = 1'b0;
            w_fault = r_fault | w_err;
          end else if (!w_hold) begin
            w_state = S_FETCH;
            w_addr  = w_next_addr;
            w_cs_n  = 1'b0;
            w_valid = 1'b0;
            w_wcnt  = '0;
          end
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  // Chip select and output enable always move together
  assign rom.rom_addr = r_addr;
  assign rom._rom_cs  = r_cs_n;
  assign rom._rom_oe  = r_cs_n;
  assign uword        = r_uword;
  assign uword_valid  = r_valid;
  assign busy         = r_busy;
  assign fault        = r_fault;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: behavioural EPROM, directed microprograms,
// expected fetch addresses queued by the stimulus and checked by a monitor.
module tb_microcode_sequencer;
  localparam int unsigned ROM_WAIT = 2;
  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, JCOND = 3'd2, CALL = 3'd3;
  localparam logic [2:0] RET = 3'd4, DISP = 3'd5, HALT = 3'd6, WAITC = 3'd7;

  logic        clk = 1'b0;
  logic        reset, start, stall;
  logic [7:0]  opcode, cond;
  logic [63:0] uword;
  logic        uword_valid, busy, fault;

  microcode_sequencer_if bus();

  logic [63:0] rom [256];
  logic [7:0]  exp_q [$];
  int          valid_t [$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  // EPROM returns data only while both selects are low
  assign bus.rom_data = (!bus._rom_cs && !bus._rom_oe) ? rom[bus.rom_addr] : 64'h0;

  microcode_sequencer #(.ROM_WAIT(ROM_WAIT), .RESET_VECTOR(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .cond(cond),
    .stall(stall), .rom(bus), .uword(uword), .uword_valid(uword_valid),
    .busy(busy), .fault(fault)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [63:0] mw(input logic [2:0] op, input logic [2:0] cs,
                                     input logic [7:0] tgt, input logic [7:0] a);
    return {op, cs, tgt, 42'h155, a};
  endfunction

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = mw(HALT, 3'd0, 8'h00, 8'(i));
  endtask

  task automatic set_w(input logic [7:0] a, input logic [2:0] op, input logic [2:0] cs,
                       input logic [7:0] tgt);
    rom[a] = mw(op, cs, tgt, a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("run_completes", 64'(n < max), 64'd1);
    check("fetch_queue_drained", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    @(negedge clk);
    while (uword_valid !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("reached_exec", 64'(n < max), 64'd1);
  endtask

  // Monitor: checks every fetch address, select timing and latched microword
  task automatic monitor();
    logic        prev_cs = 1'b1;
    logic        prev_valid = 1'b0;
    int          len = 0;
    logic [63:0] exp_uw = 64'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_cs === 1'b1 && bus._rom_cs === 1'b0) begin
        check("oe_with_cs", 64'(bus._rom_oe), 64'd0);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_fetch: got addr %0h expected no fetch (t=%0t)", bus.rom_addr, $time);
        end else begin
          check("fetch_addr", 64'(bus.rom_addr), 64'(exp_q.pop_front()));
        end
        exp_uw = rom[bus.rom_addr];
        len = 0;
      end
      if (bus._rom_cs === 1'b0) len++;
      if (prev_cs === 1'b0 && bus._rom_cs === 1'b1 && reset === 1'b0)
        check("cs_low_cycles", 64'(len), 64'(ROM_WAIT + 1));
      if (uword_valid === 1'b1 && prev_valid !== 1'b1) begin
        check("uword", uword, exp_uw);
        valid_t.push_back(cyc);
      end
      prev_cs    = bus._rom_cs;
      prev_valid = uword_valid;
    end
  endtask

  initial begin
    int s;
    reset = 1'b1; start = 1'b0; stall = 1'b0; cond = 8'h00; opcode = 8'h00;
    fill_rom();
    fork
      monitor();
    join_none
    tick();
    tick();
    check("rst_cs", 64'(bus._rom_cs), 64'd1);
    check("rst_oe", 64'(bus._rom_oe), 64'd1);
    check("rst_addr", 64'(bus.rom_addr), 64'h00);
    check("rst_uword", uword, 64'h0);
    check("rst_valid", 64'(uword_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    reset = 1'b0;
    tick();

    // Straight-line NEXT x3 then HALT
    for (int i = 0; i < 3; i++) set_w(8'(i), NEXT, 3'd0, 8'h00);
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03};
    valid_t.delete();
    pulse_start();
    s = cyc;
    check("busy_after_start", 64'(busy), 64'd1);
    wait_idle(100);
    check("valid_pulses", 64'(valid_t.size()), 64'd4);
    if (valid_t.size() > 0) check("first_valid_latency", 64'(valid_t[0] - s), 64'(ROM_WAIT + 2));
    for (int i = 1; i < valid_t.size(); i++)
      check("valid_spacing", 64'(valid_t[i] - valid_t[i-1]), 64'(ROM_WAIT + 2));
    check("halt_valid_low", 64'(uword_valid), 64'd0);
    check("halt_uword_kept", uword, rom[3]);
    check("halt_cs_high", 64'(bus._rom_cs), 64'd1);

    // JCOND taken / not taken, plus a start pulse while busy
    fill_rom();
    set_w(8'h00, JUMP, 3'd0, 8'h10);
    set_w(8'h10, JCOND, 3'd5, 8'h40);
    cond = 8'h20;
    exp_q = '{8'h00, 8'h10, 8'h40};
    pulse_start();
    tick();
    pulse_start();
    wait_idle(100);
    cond = 8'h00;
    exp_q = '{8'h00, 8'h10, 8'h11};
    pulse_start();
    wait_idle(100);

    // CALL / RET
    fill_rom();
    set_w(8'h00, JUMP, 3'd0, 8'h05);
    set_w(8'h05, CALL, 3'd0, 8'h80);
    set_w(8'h80, RET, 3'd0, 8'h00);
    exp_q = '{8'h00, 8'h05, 8'h80, 8'h06};
    pulse_start();
    wait_idle(100);
    check("call_ret_no_fault", 64'(fault), 64'd0);

    // Fifth nested CALL overflows the stack
    fill_rom();
    for (int i = 0; i < 5; i++) set_w(8'(i), CALL, 3'd0, 8'(i + 1));
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    pulse_start();
    wait_idle(100);
    check("overflow_fault", 64'(fault), 64'd1);
    check("overflow_busy", 64'(busy), 64'd0);
    repeat (10) tick();
    check("overflow_cs_idle", 64'(bus._rom_cs), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("fault_cleared_by_reset", 64'(fault), 64'd0);

    // RET with empty stack
    fill_rom();
    set_w(8'h00, RET, 3'd0, 8'h00);
    exp_q = '{8'h00};
    pulse_start();
    wait_idle(100);
    check("underflow_fault", 64'(fault), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // DISPATCH and address wrap FF -> 00
    fill_rom();
    set_w(8'h00, DISP, 3'd0, 8'h00);
    set_w(8'hFF, NEXT, 3'd0, 8'h00);
    opcode = 8'hFF;
    exp_q = '{8'h00, 8'hFF, 8'h00, 8'hA7};
    pulse_start();
    s = 0;
    while (!(bus._rom_cs === 1'b0 && bus.rom_addr === 8'hFF) && s < 50) begin
      @(negedge clk);
      s++;
    end
    check("reached_ff", 64'(s < 50), 64'd1);
    tick();
    opcode = 8'hA7;
    wait_idle(100);

    // Stall across a JUMP for five edges
    fill_rom();
    set_w(8'h00, JUMP, 3'd0, 8'h30);
    exp_q = '{8'h00, 8'h30};
    pulse_start();
    wait_valid(50);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(uword_valid), 64'd1);
      check("stall_uword", uword, rom[0]);
      check("stall_cs", 64'(bus._rom_cs), 64'd1);
    end
    stall = 1'b0;
    @(negedge clk);
    check("jump_after_stall", 64'(bus.rom_addr), 64'h30);
    wait_idle(100);

    // WAIT holds until cond[3] rises
    fill_rom();
    set_w(8'h00, WAITC, 3'd3, 8'h00);
    cond = 8'h00;
    exp_q = '{8'h00, 8'h01};
    pulse_start();
    wait_valid(50);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("wait_valid", 64'(uword_valid), 64'd1);
      check("wait_cs", 64'(bus._rom_cs), 64'd1);
    end
    cond = 8'h08;
    @(negedge clk);
    check("wait_release", 64'(bus.rom_addr), 64'h01);
    wait_idle(100);
    cond = 8'h00;

    // Reset during FETCH
    fill_rom();
    set_w(8'h00, NEXT, 3'd0, 8'h00);
    exp_q = '{8'h00};
    pulse_start();
    tick();
    check("pre_reset_fetching", 64'(bus._rom_cs), 64'd0);
    reset = 1'b1;
    tick();
    check("reset_fetch_cs", 64'(bus._rom_cs), 64'd1);
    check("reset_fetch_oe", 64'(bus._rom_oe), 64'd1);
    check("reset_fetch_busy", 64'(busy), 64'd0);
    check("reset_fetch_uword", uword, 64'h0);
    check("reset_fetch_addr", 64'(bus.rom_addr), 64'h00);
    tick();
    reset = 1'b0;
    repeat (8) tick();
    check("no_fetch_after_reset", 64'(exp_q.size()), 64'd0);
    check("idle_after_reset", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
